reg_wb_buf: RTL and testbench

Writeback buffer that feeds the register file's write port (`we`/`wa`/`wd`). Accepts results from the ALU and the load path, up to two per cycle, and queues them in a small in-order FIFO. Retires one write per cycle to the register file. Also reports, for the decode-stage read addresses, whether a write to that register is still pending, so decode can stall instead of reading a stale value.

---
 rtl/reg_wb_buf_pkg.sv | 5 +
 rtl/reg_wb_buf_if.sv | 36 +++
 rtl/reg_wb_buf_fifo.sv | 64 ++++++
 rtl/reg_wb_buf.sv | 89 ++++++++
 tb/tb_reg_wb_buf.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/reg_wb_buf_pkg.sv
// rtl/reg_wb_buf_pkg.sv - shared widths and defaults for the writeback buffer
package reg_wb_buf_pkg;
  localparam int FULLW    = 32;
  localparam int WB_DEPTH = 4;
endpackage

// File: rtl/reg_wb_buf_if.sv
// rtl/reg_wb_buf_if.sv - writeback request, register-file write and hazard-query bundle
interface reg_wb_buf_if
  import reg_wb_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = WB_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_addr;
  logic [FULLW-1:0]      alu_data;
  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [FULLW-1:0]      ld_data;
  logic                  ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] wa;
  logic [FULLW-1:0]      wd;
  logic [ADDR_WIDTH-1:0] rd1;
  logic [ADDR_WIDTH-1:0] rd2;
  logic                  busy1;
  logic                  busy2;
  logic [CW-1:0]         count;
  logic                  ovf;

  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, rd1, rd2,
    input  ready, we, wa, wd, busy1, busy2, count, ovf
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, rd1, rd2,
    output ready, we, wa, wd, busy1, busy2, count, ovf
  );
endinterface

// File: rtl/reg_wb_buf_fifo.sv
// rtl/reg_wb_buf_fifo.sv - two-write one-read circular buffer exposing its entries
module wb_fifo2w1r
  import reg_wb_buf_pkg::*;
#(
  parameter int AW    = 4,
  parameter int DW    = FULLW,
  parameter int DEPTH = WB_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] data0,
  input  logic          push1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] data1,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count,
  output logic [DEPTH-1:0] ent_valid,
  output logic [AW-1:0] ent_addr [DEPTH]
);
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW-1:0] wp1;
  logic [DW-1:0] mem_data [DEPTH];

  assign wp1       = wp + 1'b1;
  assign head_addr = ent_addr[rp];
  assign head_data = mem_data[rp];

  // push1 is only ever raised together with push0, so it always lands in the slot after wp
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (pop) begin
        ent_valid[rp] <= 1'b0;
        rp            <= rp + 1'b1;
      end
      if (push0) ent_valid[wp]  <= 1'b1;
      if (push1) ent_valid[wp1] <= 1'b1;
      wp    <= wp + PW'(push0) + PW'(push1);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push0) begin
      ent_addr[wp] <= addr0;
      mem_data[wp] <= data0;
    end
    if (push1) begin
      ent_addr[wp1] <= addr1;
      mem_data[wp1] <= data1;
    end
  end
endmodule

// File: rtl/reg_wb_buf.sv
// rtl/reg_wb_buf.sv - in-order writeback buffer driving the register-file write port
module reg_wb_buf
  import reg_wb_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = WB_DEPTH
) (
  input logic         clk,
  input logic         reset,
  reg_wb_buf_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]         cnt;
  logic                  ready;
  logic                  any_req;
  logic                  push0;
  logic                  push1;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [FULLW-1:0]      data0;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [FULLW-1:0]      head_data;
  logic [DEPTH-1:0]      ent_valid;
  logic [ADDR_WIDTH-1:0] ent_addr [DEPTH];
  logic                  busy1;
  logic                  busy2;

  // Two free slots are required so a paired ld+alu push can never be split
  assign ready   = (cnt <= CW'(DEPTH - 2));
  assign any_req = bus.ld_valid | bus.alu_valid;
  assign push0   = ready & any_req;
  assign push1   = ready & bus.ld_valid & bus.alu_valid;
  assign addr0   = bus.ld_valid ? bus.ld_addr : bus.alu_addr;
  assign data0   = bus.ld_valid ? bus.ld_data : bus.alu_data;
  assign pop     = (cnt != '0);

  wb_fifo2w1r #(
    .AW    (ADDR_WIDTH),
    .DW    (FULLW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push0     (push0),
    .addr0     (addr0),
    .data0     (data0),
    .push1     (push1),
    .addr1     (bus.alu_addr),
    .data1     (bus.alu_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (cnt),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.we  <= 1'b0;
      bus.wa  <= '0;
      bus.wd  <= '0;
      bus.ovf <= 1'b0;
    end else begin
      bus.we <= pop;
      if (pop) begin
        bus.wa <= head_addr;
        bus.wd <= head_data;
      end
      if (!ready && any_req) bus.ovf <= 1'b1;
    end
  end

  // The in-flight write counts as pending: the register file still returns the old value that cycle
  always_comb begin
    busy1 = bus.we && (bus.wa == bus.rd1);
    busy2 = bus.we && (bus.wa == bus.rd2);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == bus.rd1)) busy1 = 1'b1;
      if (ent_valid[i] && (ent_addr[i] == bus.rd2)) busy2 = 1'b1;
    end
  end

  assign bus.ready = ready;
  assign bus.count = cnt;
  assign bus.busy1 = busy1;
  assign bus.busy2 = busy2;
endmodule

// File: tb/tb_reg_wb_buf.sv
// tb/tb_reg_wb_buf.sv - directed and random checks of reg_wb_buf against a queue model
module tb_reg_wb_buf;
  import reg_wb_buf_pkg::*;

  localparam int AW = 4;
  localparam int D  = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } ent_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reg_wb_buf_if #(.ADDR_WIDTH(AW), .DEPTH(D)) bus ();

  reg_wb_buf #(.ADDR_WIDTH(AW), .DEPTH(D)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  int          wcnt     = 0;
  int          w0;
  ent_t        q[$];
  logic        m_we;
  logic [AW-1:0] m_wa;
  logic [31:0] m_wd;
  logic        m_ovf;
  logic [31:0] rf [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_busy(input logic [AW-1:0] r);
    logic b;
    b = m_we && (m_wa == r);
    foreach (q[i]) if (q[i].a == r) b = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    q.delete();
    m_we  = 1'b0;
    m_wa  = '0;
    m_wd  = '0;
    m_ovf = 1'b0;
  endtask

  task automatic step(input logic lv, input logic [AW-1:0] la, input logic [31:0] ldd,
                      input logic av, input logic [AW-1:0] aa, input logic [31:0] ad,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    ent_t e;
    bit   rdy;
    bus.ld_valid  = lv;
    bus.ld_addr   = la;
    bus.ld_data   = ldd;
    bus.alu_valid = av;
    bus.alu_addr  = aa;
    bus.alu_data  = ad;
    bus.rd1       = r1;
    bus.rd2       = r2;
    #1;
    chk("ready", 32'(bus.ready), 32'(q.size() <= D - 2));
    chk("busy1", 32'(bus.busy1), 32'(m_busy(r1)));
    chk("busy2", 32'(bus.busy2), 32'(m_busy(r2)));
    @(posedge clk);
    rdy = (q.size() <= D - 2);
    if (q.size() > 0) begin
      e    = q.pop_front();
      m_we = 1'b1;
      m_wa = e.a;
      m_wd = e.d;
    end else begin
      m_we = 1'b0;
    end
    if (rdy) begin
      if (lv) q.push_back('{a: la, d: ldd});
      if (av) q.push_back('{a: aa, d: ad});
    end else if (lv || av) begin
      m_ovf = 1'b1;
    end
    #1;
    chk("we", 32'(bus.we), 32'(m_we));
    chk("wa", 32'(bus.wa), 32'(m_wa));
    chk("wd", bus.wd, m_wd);
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
    if (bus.we) begin
      rf[bus.wa] = bus.wd;
      wcnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, '0, '0, 1'b0, '0, '0, AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
  endtask

  initial begin
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    bus.alu_valid = 1'b0;
    bus.alu_addr  = '0;
    bus.alu_data  = '0;
    bus.rd1       = 4'd3;
    bus.rd2       = 4'd0;
    model_reset();

    #2;
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_wa", 32'(bus.wa), 32'd0);
    chk("rst_wd", bus.wd, 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_busy1", 32'(bus.busy1), 32'd0);
    #10 reset = 1'b1;

    // single load, latency and hazard window
    step(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, '0, '0, 4'd3, 4'd0);
    chk("t1_busy1_e1", 32'(bus.busy1), 32'd1);
    step(1'b0, '0, '0, 1'b0, '0, '0, 4'd3, 4'd0);
    chk("t1_we_e2", 32'(bus.we), 32'd1);
    chk("t1_wa_e2", 32'(bus.wa), 32'd3);
    chk("t1_wd_e2", bus.wd, 32'hDEADBEEF);
    chk("t1_busy1_e2", 32'(bus.busy1), 32'd1);
    step(1'b0, '0, '0, 1'b0, '0, '0, 4'd3, 4'd0);
    chk("t1_busy1_e3", 32'(bus.busy1), 32'd0);

    // same-address pair: alu value must win
    step(1'b1, 4'd5, 32'h11, 1'b1, 4'd5, 32'h22, 4'd5, 4'd5);
    idle(3);
    chk("t2_rf5", rf[5], 32'h22);

    // saturating two-per-cycle input
    w0 = wcnt;
    step(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hA2, 4'd1, 4'd2);
    step(1'b1, 4'd3, 32'hB1, 1'b1, 4'd4, 32'hB2, 4'd3, 4'd4);
    chk("t3_ready_low", 32'(bus.ready), 32'd0);
    step(1'b1, 4'd6, 32'hC1, 1'b1, 4'd7, 32'hC2, 4'd6, 4'd7);
    idle(5);
    chk("t3_ovf", 32'(bus.ovf), 32'd1);
    chk("t3_writes", 32'(wcnt - w0), 32'd4);

    // idle hold
    idle(4);

    // asynchronous reset with entries queued
    step(1'b1, 4'd8, 32'hD1, 1'b1, 4'd9, 32'hD2, 4'd8, 4'd9);
    step(1'b1, 4'd10, 32'hE1, 1'b1, 4'd11, 32'hE2, 4'd10, 4'd11);
    bus.ld_valid  = 1'b0;
    bus.alu_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("ar_we", 32'(bus.we), 32'd0);
    chk("ar_count", 32'(bus.count), 32'd0);
    chk("ar_ovf", 32'(bus.ovf), 32'd0);
    chk("ar_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    w0 = wcnt;
    idle(5);
    chk("ar_no_writes", 32'(wcnt - w0), 32'd0);

    // alternating single alu pushes, pointers wrap
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, '0, 1'((i % 2) == 0), AW'($urandom_range(0, 15)), $urandom(),
           AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
      chk("wrap_cnt_le1", 32'(bus.count <= 1), 32'd1);
    end
    idle(2);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom(),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom(),
           AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
